// File: rtl/vending_machine_multi_if.sv
// Handshake and status bundle of the multi-product vending controller.
// master: coin acceptor / dispenser / hopper side; slave: the controller.
interface vending_machine_multi_if #(
    parameter int CREDIT_W = 8,
    parameter int N_PROD   = 4,
    parameter int SEL_W    = 2
);
    logic                coin_valid;
    logic [CREDIT_W-1:0] coin_val;
    logic                coin_reject;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel_id;
    logic                sel_err;
    logic                cancel;
    logic                prod_valid;
    logic [SEL_W-1:0]    prod_id;
    logic                prod_ready;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic                change_ready;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                restock;
    logic [N_PROD-1:0]   sold_out;

    modport master (
        output coin_valid, coin_val, sel_valid, sel_id, cancel,
        output prod_ready, change_ready, restock,
        input  coin_reject, sel_err, prod_valid, prod_id,
        input  change_valid, change_amt, credit, busy, sold_out
    );

    modport slave (
        input  coin_valid, coin_val, sel_valid, sel_id, cancel,
        input  prod_ready, change_ready, restock,
        output coin_reject, sel_err, prod_valid, prod_id,
        output change_valid, change_amt, credit, busy, sold_out
    );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller with credit accumulator and change return.
// Optional per-product stock counters are enabled with `define INVENTORY_EN.
module vending_machine_multi #(
    parameter int CREDIT_W = 8,
    parameter int N_PROD   = 4,
    parameter int SEL_W    = 2,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICE_LIST =
        {8'd15, 8'd10, 8'd5, 8'd3},
    parameter int MAX_CREDIT = 50,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input logic clk,
    input logic rst,
    vending_machine_multi_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    pid_q, pid_d;
    logic                rej_q, rej_d;
    logic                err_q, err_d;
    logic                vend_done;

    logic [CREDIT_W-1:0] price_sel;
    logic                id_ok;
    logic                in_stock;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic                sel_ok;

    // Price of the requested product; id_ok flags an existing product
    always_comb begin
        price_sel = '0;
        id_ok     = 1'b0;
        for (int i = 0; i < N_PROD; i++) begin
            if (bus.sel_id == SEL_W'(i)) begin
                price_sel = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
                id_ok     = 1'b1;
            end
        end
    end

    assign coin_sum = {1'b0, credit_q} + {1'b0, bus.coin_val};
    assign coin_ok  = (bus.coin_val != '0) &&
                      (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign sel_ok   = id_ok && (credit_q >= price_sel) && in_stock;

`ifdef INVENTORY_EN
    logic [STOCK_W-1:0] stock_q [N_PROD];

    // Stock of the requested product is non-zero
    always_comb begin
        in_stock = 1'b0;
        for (int i = 0; i < N_PROD; i++) begin
            if (bus.sel_id == SEL_W'(i)) in_stock = (stock_q[i] != '0);
        end
    end

    // Stock counters: restock reload beats a dispense decrement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_PROD; i++)
                stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else if (bus.restock) begin
            for (int i = 0; i < N_PROD; i++)
                stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            for (int i = 0; i < N_PROD; i++) begin
                if (vend_done && pid_q == SEL_W'(i) && stock_q[i] != '0)
                    stock_q[i] <= stock_q[i] - STOCK_W'(1);
            end
        end
    end

    // Sold-out flags straight from the counters
    always_comb begin
        bus.sold_out = '0;
        for (int i = 0; i < N_PROD; i++)
            bus.sold_out[i] = (stock_q[i] == '0);
    end
`else
    logic unused_restock;
    assign unused_restock = bus.restock;
    assign in_stock       = 1'b1;
    assign bus.sold_out   = '0;
`endif

    // State, credit and pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            pid_q    <= '0;
            rej_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            pid_q    <= pid_d;
            rej_q    <= rej_d;
            err_q    <= err_d;
        end
    end

    // Next state: cancel > select > coin while taking money
    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        pid_d     = pid_q;
        rej_d     = 1'b0;
        err_d     = 1'b0;
        vend_done = 1'b0;
        unique case (state_q)
            IDLE, COLLECT: begin
                if (bus.cancel && state_q == COLLECT) begin
                    state_d = CHANGE;
                    rej_d   = bus.coin_valid;
                end else if (bus.sel_valid) begin
                    rej_d = bus.coin_valid;
                    if (sel_ok) begin
                        credit_d = credit_q - price_sel;
                        pid_d    = bus.sel_id;
                        state_d  = VEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = COLLECT;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            VEND: begin
                rej_d = bus.coin_valid;
                if (bus.prod_ready) begin
                    vend_done = 1'b1;
                    state_d   = (credit_q != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                rej_d = bus.coin_valid;
                if (bus.change_ready) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        bus.prod_valid   = (state_q == VEND);
        bus.prod_id      = (state_q == VEND) ? pid_q : '0;
        bus.change_valid = (state_q == CHANGE);
        bus.change_amt   = (state_q == CHANGE) ? credit_q : '0;
        bus.busy         = (state_q == VEND) || (state_q == CHANGE);
        bus.credit       = credit_q;
        bus.coin_reject  = rej_q;
        bus.sel_err      = err_q;
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Self-checking bench for vending_machine_multi: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_vending_machine_multi;

    localparam int CW = 8;
    localparam int NP = 4;
    localparam int SW = 3;
    localparam int SI = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   price [NP] = '{15, 10, 5, 3};

    vending_machine_multi_if #(.CREDIT_W(CW), .N_PROD(NP), .SEL_W(SW)) bus ();

    vending_machine_multi #(
        .CREDIT_W(CW), .N_PROD(NP), .SEL_W(SW),
        .PRICE_LIST({8'd3, 8'd5, 8'd10, 8'd15}),
        .MAX_CREDIT(50), .STOCK_W(4), .STOCK_INIT(SI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr;
        bus.coin_valid   = 1'b0;
        bus.coin_val     = '0;
        bus.sel_valid    = 1'b0;
        bus.sel_id       = '0;
        bus.cancel       = 1'b0;
        bus.prod_ready   = 1'b0;
        bus.change_ready = 1'b0;
        bus.restock      = 1'b0;
    endtask

    task automatic do_reset;
        clr();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic put_coin(input int v);
        bus.coin_valid = 1'b1;
        bus.coin_val   = CW'(v);
        tick();
        clr();
    endtask

    task automatic pick(input int id);
        bus.sel_valid = 1'b1;
        bus.sel_id    = SW'(id);
        tick();
        clr();
    endtask

    task automatic test_reset;
        do_reset();
        put_coin(5);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.credit !== 8'd0) begin n_bad++; $display("FAIL rst_credit got %0d want 0", bus.credit); end
        n_cmp++; if ({bus.prod_valid, bus.change_valid, bus.busy, bus.coin_reject, bus.sel_err} !== 5'b0) begin
            n_bad++; $display("FAIL rst_flags got %b want 00000", {bus.prod_valid, bus.change_valid, bus.busy, bus.coin_reject, bus.sel_err});
        end
        n_cmp++; if (bus.sold_out !== 4'b0) begin n_bad++; $display("FAIL rst_sold_out got %b want 0000", bus.sold_out); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_exact_vend;
        do_reset();
        put_coin(5); put_coin(5); put_coin(5);
        n_cmp++; if (bus.credit !== 8'd15) begin n_bad++; $display("FAIL exact_credit got %0d want 15", bus.credit); end
        pick(0);
        n_cmp++; if (bus.prod_valid !== 1'b1 || bus.prod_id !== 3'd0) begin
            n_bad++; $display("FAIL exact_vend got v=%b id=%0d want v=1 id=0", bus.prod_valid, bus.prod_id);
        end
        n_cmp++; if (bus.credit !== 8'd0) begin n_bad++; $display("FAIL exact_credit_after got %0d want 0", bus.credit); end
        tick();
        n_cmp++; if (bus.prod_valid !== 1'b1) begin n_bad++; $display("FAIL exact_hold got %b want 1", bus.prod_valid); end
        bus.prod_ready = 1'b1;
        tick();
        clr();
        n_cmp++; if ({bus.prod_valid, bus.change_valid, bus.busy} !== 3'b0) begin
            n_bad++; $display("FAIL exact_done got %b want 000", {bus.prod_valid, bus.change_valid, bus.busy});
        end
    endtask

    task automatic test_vend_change;
        do_reset();
        put_coin(10); put_coin(10);
        pick(1);
        n_cmp++; if (bus.prod_valid !== 1'b1 || bus.prod_id !== 3'd1 || bus.credit !== 8'd10) begin
            n_bad++; $display("FAIL chg_vend got v=%b id=%0d cr=%0d want v=1 id=1 cr=10", bus.prod_valid, bus.prod_id, bus.credit);
        end
        bus.change_ready = 1'b1;
        tick();
        n_cmp++; if (bus.prod_valid !== 1'b1) begin n_bad++; $display("FAIL chg_ready_ignored got %b want 1", bus.prod_valid); end
        clr();
        bus.prod_ready = 1'b1;
        tick();
        clr();
        n_cmp++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 8'd10 || bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL chg_change got v=%b amt=%0d want v=1 amt=10", bus.change_valid, bus.change_amt);
        end
        bus.change_ready = 1'b1;
        tick();
        clr();
        n_cmp++; if (bus.credit !== 8'd0 || bus.change_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL chg_done got cr=%0d v=%b want cr=0 v=0", bus.credit, bus.change_valid);
        end
    endtask

    task automatic test_sel_err;
        do_reset();
        put_coin(3);
        pick(2);
        n_cmp++; if (bus.sel_err !== 1'b1 || bus.credit !== 8'd3 || bus.prod_valid !== 1'b0) begin
            n_bad++; $display("FAIL err_low got err=%b cr=%0d pv=%b want err=1 cr=3 pv=0", bus.sel_err, bus.credit, bus.prod_valid);
        end
        tick();
        n_cmp++; if (bus.sel_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse got %b want 0", bus.sel_err); end
        pick(5);
        n_cmp++; if (bus.sel_err !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL err_range got err=%b busy=%b want 1 0", bus.sel_err, bus.busy);
        end
        put_coin(0);
        n_cmp++; if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd3) begin
            n_bad++; $display("FAIL zero_coin got rej=%b cr=%0d want 1 3", bus.coin_reject, bus.credit);
        end
    endtask

    task automatic test_max_cancel;
        do_reset();
        bus.cancel = 1'b1;
        tick();
        clr();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL cancel_idle got busy=%b want 0", bus.busy); end
        put_coin(20); put_coin(20); put_coin(5);
        put_coin(10);
        n_cmp++; if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd45) begin
            n_bad++; $display("FAIL max_reject got rej=%b cr=%0d want 1 45", bus.coin_reject, bus.credit);
        end
        put_coin(5);
        n_cmp++; if (bus.coin_reject !== 1'b0 || bus.credit !== 8'd50) begin
            n_bad++; $display("FAIL max_edge got rej=%b cr=%0d want 0 50", bus.coin_reject, bus.credit);
        end
        bus.cancel = 1'b1;
        tick();
        clr();
        n_cmp++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 8'd50) begin
            n_bad++; $display("FAIL refund got v=%b amt=%0d want 1 50", bus.change_valid, bus.change_amt);
        end
        put_coin(5);
        n_cmp++; if (bus.coin_reject !== 1'b1 || bus.change_amt !== 8'd50) begin
            n_bad++; $display("FAIL coin_in_change got rej=%b amt=%0d want 1 50", bus.coin_reject, bus.change_amt);
        end
        bus.change_ready = 1'b1;
        tick();
        clr();
    endtask

    task automatic test_same_cycle;
        do_reset();
        put_coin(10);
        bus.sel_valid  = 1'b1;
        bus.sel_id     = 3'd1;
        bus.coin_valid = 1'b1;
        bus.coin_val   = 8'd5;
        tick();
        clr();
        n_cmp++; if (bus.prod_valid !== 1'b1 || bus.coin_reject !== 1'b1 || bus.credit !== 8'd0) begin
            n_bad++; $display("FAIL same_cycle got pv=%b rej=%b cr=%0d want 1 1 0", bus.prod_valid, bus.coin_reject, bus.credit);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({bus.prod_valid, bus.busy, bus.coin_reject} !== 3'b0 || bus.prod_id !== 3'd0) begin
            n_bad++; $display("FAIL rst_mid_vend got %b id=%0d want 000 id=0", {bus.prod_valid, bus.busy, bus.coin_reject}, bus.prod_id);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_inventory;
        do_reset();
        put_coin(3);
        pick(3);
        bus.prod_ready = 1'b1;
        tick();
        clr();
`ifdef INVENTORY_EN
        n_cmp++; if (bus.sold_out !== 4'b1000) begin n_bad++; $display("FAIL inv_sold_out got %b want 1000", bus.sold_out); end
        put_coin(3);
        pick(3);
        n_cmp++; if (bus.sel_err !== 1'b1 || bus.credit !== 8'd3) begin
            n_bad++; $display("FAIL inv_sel_err got err=%b cr=%0d want 1 3", bus.sel_err, bus.credit);
        end
        bus.restock = 1'b1;
        tick();
        clr();
        n_cmp++; if (bus.sold_out !== 4'b0000) begin n_bad++; $display("FAIL inv_restock got %b want 0000", bus.sold_out); end
        pick(3);
        n_cmp++; if (bus.prod_valid !== 1'b1 || bus.prod_id !== 3'd3) begin
            n_bad++; $display("FAIL inv_revend got pv=%b id=%0d want 1 3", bus.prod_valid, bus.prod_id);
        end
`else
        put_coin(3);
        pick(3);
        n_cmp++; if (bus.prod_valid !== 1'b1 || bus.sold_out !== 4'b0) begin
            n_bad++; $display("FAIL inv_unlimited got pv=%b so=%b want 1 0000", bus.prod_valid, bus.sold_out);
        end
`endif
        bus.prod_ready = 1'b1;
        tick();
        clr();
    endtask

    task automatic test_random;
        int  m_credit;
        bit  m_vend;
        bit  m_change;
        int  m_vid;
        int  m_stock [NP];
        bit  e_rej;
        bit  e_err;
        bit  ok;
        int  cval;
        int  sid;
        logic [NP-1:0] e_so;
        do_reset();
        m_credit = 0; m_vend = 0; m_change = 0; m_vid = 0;
        for (int i = 0; i < NP; i++) m_stock[i] = SI;
        for (int c = 0; c < 800; c++) begin
            cval = $urandom_range(0, 20);
            sid  = $urandom_range(0, 5);
            bus.coin_valid   = ($urandom % 10) < 4;
            bus.coin_val     = CW'(cval);
            bus.sel_valid    = ($urandom % 6) == 0;
            bus.sel_id       = SW'(sid);
            bus.cancel       = ($urandom % 16) == 0;
            bus.prod_ready   = $urandom % 2;
            bus.change_ready = $urandom % 2;
            bus.restock      = ($urandom % 20) == 0;
            e_rej = 0;
            e_err = 0;
            if (m_vend) begin
                e_rej = bus.coin_valid;
                if (bus.prod_ready) begin
                    m_vend = 0;
                    m_change = (m_credit > 0);
`ifdef INVENTORY_EN
                    if (!bus.restock && m_stock[m_vid] > 0) m_stock[m_vid]--;
`endif
                end
            end else if (m_change) begin
                e_rej = bus.coin_valid;
                if (bus.change_ready) begin
                    m_change = 0;
                    m_credit = 0;
                end
            end else if (bus.cancel && m_credit > 0) begin
                m_change = 1;
                e_rej = bus.coin_valid;
            end else if (bus.sel_valid) begin
                e_rej = bus.coin_valid;
                ok = (sid < NP) && (m_credit >= price[sid % NP]);
`ifdef INVENTORY_EN
                ok = ok && (m_stock[sid % NP] > 0);
`endif
                if (ok) begin
                    m_credit -= price[sid];
                    m_vend = 1;
                    m_vid = sid;
                end else begin
                    e_err = 1;
                end
            end else if (bus.coin_valid) begin
                if (cval != 0 && m_credit + cval <= 50) m_credit += cval;
                else e_rej = 1;
            end
`ifdef INVENTORY_EN
            if (bus.restock) for (int i = 0; i < NP; i++) m_stock[i] = SI;
            for (int i = 0; i < NP; i++) e_so[i] = (m_stock[i] == 0);
`else
            e_so = '0;
`endif
            tick();
            n_cmp++; if (bus.credit !== CW'(m_credit) || bus.coin_reject !== e_rej || bus.sel_err !== e_err) begin
                n_bad++; $display("FAIL rnd_money c=%0d got cr=%0d rej=%b err=%b want cr=%0d rej=%b err=%b",
                    c, bus.credit, bus.coin_reject, bus.sel_err, m_credit, e_rej, e_err);
            end
            n_cmp++; if (bus.prod_valid !== m_vend || bus.change_valid !== m_change || bus.busy !== (m_vend | m_change)) begin
                n_bad++; $display("FAIL rnd_phase c=%0d got pv=%b cv=%b busy=%b want pv=%b cv=%b",
                    c, bus.prod_valid, bus.change_valid, bus.busy, m_vend, m_change);
            end
            if (m_vend) begin
                n_cmp++; if (bus.prod_id !== SW'(m_vid)) begin
                    n_bad++; $display("FAIL rnd_prod_id c=%0d got %0d want %0d", c, bus.prod_id, m_vid);
                end
            end
            if (m_change) begin
                n_cmp++; if (bus.change_amt !== CW'(m_credit)) begin
                    n_bad++; $display("FAIL rnd_change_amt c=%0d got %0d want %0d", c, bus.change_amt, m_credit);
                end
            end
            n_cmp++; if (bus.sold_out !== e_so) begin
                n_bad++; $display("FAIL rnd_sold_out c=%0d got %b want %b", c, bus.sold_out, e_so);
            end
        end
        clr();
    endtask

    initial begin
        clr();
        test_reset();
        test_exact_vend();
        test_vend_change();
        test_sel_err();
        test_max_cancel();
        test_same_cycle();
        test_inventory();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
